// File: rtl/des_cbc_ctrl_pkg.sv
// rtl/des_cbc_ctrl_pkg.sv - shared types, constants and chaining helper for the DES CBC controller
package des_pkg;

  typedef logic [63:0] des_block_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_READY,
    ST_BUSY,
    ST_OUT
  } ctrl_state_t;

  // Core key-schedule programming latency, in clk_en-qualified cycles.
  localparam int KEY_WAIT_CYCLES = 2;

  // Block-chaining XOR; bypass selects the raw block (ECB-style, no chaining).
  function automatic des_block_t chain_xor(des_block_t blk, des_block_t chain, logic bypass);
    return bypass ? blk : (blk ^ chain);
  endfunction

endpackage

// File: rtl/des_cbc_ctrl_if.sv
// rtl/des_cbc_ctrl_if.sv - block stream interface (input and result channels) for the DES CBC controller
interface des_cbc_ctrl_if;

  des_pkg::des_block_t in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;
  des_pkg::des_block_t out_data;
  logic                out_valid;
  logic                out_last;
  logic                out_ready;

  // Host side: produces input blocks, consumes results.
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  // Controller side.
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/des_cbc_ctrl.sv
// rtl/des_cbc_ctrl.sv - CBC chaining controller for the iterative DES core (optional ECB bypass: DES_CBC_ECB_EN)
module des_cbc_ctrl
  import des_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  des_block_t       cfg_key,
  input  des_block_t       cfg_iv,
  input  logic             cfg_decrypt,
`ifdef DES_CBC_ECB_EN
  input  logic             cfg_ecb,
`endif
  input  logic             cfg_load,
  output logic             cfg_ready,
  des_cbc_ctrl_if.slave    strm,
  output des_block_t       core_data_in,
  output logic             core_data_en,
  output des_block_t       core_key_in,
  output logic             core_mode_in,
  output logic             core_key_en,
  input  des_block_t       core_data_out,
  input  logic             core_busy,
  input  logic             core_wr,
  output logic [CNT_W-1:0] blk_cnt
);

  ctrl_state_t      state_q, state_d;
  des_block_t       key_q, iv_q, chain_q, pend_q, core_din_q, out_data_q;
  logic             dec_q, last_q, key_loaded_q;
  logic             core_den_q, core_ken_q, out_valid_q, out_last_q;
  logic [1:0]       cnt_q;
  logic [CNT_W-1:0] blk_cnt_q;
  logic             ecb_q;

  logic in_ready, cfg_acc, in_acc, core_done, key_done, out_ack;

`ifdef DES_CBC_ECB_EN
  // ECB selection is captured together with the rest of the configuration.
  always_ff @(posedge clk) begin
    if (!rst) ecb_q <= 1'b0;
    else if (clk_en && cfg_acc) ecb_q <= cfg_ecb;
  end
`else
  assign ecb_q = 1'b0;
`endif

  // Next-state and handshake decode; every strobe is clk_en-qualified.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    cfg_acc   = 1'b0;
    in_acc    = 1'b0;
    core_done = 1'b0;
    key_done  = 1'b0;
    out_ack   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_load) begin
          cfg_acc = 1'b1;
          state_d = ST_KEY;
        end
      end
      ST_KEY: begin
        if (cnt_q == 2'(KEY_WAIT_CYCLES - 1)) begin
          key_done = 1'b1;
          state_d  = ST_READY;
        end
      end
      ST_READY: begin
        cfg_ready = 1'b1;
        // A new configuration beats a simultaneous block; never launch into a busy core.
        in_ready  = !cfg_load && key_loaded_q && !core_busy;
        if (cfg_load) begin
          cfg_acc = 1'b1;
          state_d = ST_KEY;
        end else if (strm.in_valid && in_ready) begin
          in_acc  = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (core_wr) begin
          core_done = 1'b1;
          state_d   = ST_OUT;
        end
      end
      ST_OUT: begin
        if (strm.out_ready) begin
          out_ack = 1'b1;
          state_d = ST_READY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!clk_en) begin
      state_d   = state_q;
      cfg_acc   = 1'b0;
      in_acc    = 1'b0;
      core_done = 1'b0;
      key_done  = 1'b0;
      out_ack   = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else state_q <= state_d;
  end

  // Configuration, chaining datapath, core strobes and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_q        <= '0;
      iv_q         <= '0;
      dec_q        <= 1'b0;
      chain_q      <= '0;
      pend_q       <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      key_loaded_q <= 1'b0;
      core_din_q   <= '0;
      core_den_q   <= 1'b0;
      core_ken_q   <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      blk_cnt_q    <= '0;
    end else if (clk_en) begin
      core_den_q <= in_acc;
      core_ken_q <= cfg_acc;
      if (cfg_acc) begin
        key_q        <= cfg_key;
        iv_q         <= cfg_iv;
        dec_q        <= cfg_decrypt;
        chain_q      <= cfg_iv;
        cnt_q        <= '0;
        key_loaded_q <= 1'b0;
      end
      if (state_q == ST_KEY && !key_done) cnt_q <= cnt_q + 2'd1;
      if (key_done) key_loaded_q <= 1'b1;
      if (in_acc) begin
        core_din_q <= dec_q ? strm.in_data : chain_xor(strm.in_data, chain_q, ecb_q);
        pend_q     <= strm.in_data;
        last_q     <= strm.in_last;
      end
      if (core_done) begin
        out_data_q  <= dec_q ? chain_xor(core_data_out, chain_q, ecb_q) : core_data_out;
        out_valid_q <= 1'b1;
        out_last_q  <= last_q;
        blk_cnt_q   <= blk_cnt_q + 1'b1;
        // End of message rewinds the chain so the next message starts from the IV.
        if (!ecb_q) begin
          if (last_q) chain_q <= iv_q;
          else if (dec_q) chain_q <= pend_q;
          else chain_q <= core_data_out;
        end
      end
      if (out_ack) out_valid_q <= 1'b0;
    end
  end

  assign strm.in_ready  = in_ready;
  assign strm.out_data  = out_data_q;
  assign strm.out_valid = out_valid_q;
  assign strm.out_last  = out_last_q;
  assign core_data_in   = core_din_q;
  assign core_data_en   = core_den_q;
  assign core_key_in    = key_q;
  assign core_mode_in   = dec_q;
  assign core_key_en    = core_ken_q;
  assign blk_cnt        = blk_cnt_q;

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// tb/tb_des_cbc_ctrl.sv - scoreboard bench for des_cbc_ctrl with a behavioural DES core
`timescale 1ns/1ps
module tb_des_cbc_ctrl;
  import des_pkg::*;

  localparam int CORE_LAT = 4;

  localparam int IP_T[64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                              64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                              61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP_T[64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                              37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                              34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E_T[48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                             16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T[32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                             2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1_T[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                               60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,
                               61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                               41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SH_T[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SBOX[512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_en = 1'b1;
  des_block_t cfg_key = '0, cfg_iv = '0;
  logic       cfg_decrypt = 1'b0, cfg_load = 1'b0, cfg_ready;
  des_block_t core_data_in, core_key_in, core_data_out;
  logic       core_data_en, core_mode_in, core_key_en;
  logic       core_busy, core_wr;
  logic [1:0] blk_cnt;

  des_cbc_ctrl_if bus ();

  des_cbc_ctrl #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .cfg_key(cfg_key), .cfg_iv(cfg_iv), .cfg_decrypt(cfg_decrypt),
`ifdef DES_CBC_ECB_EN
    .cfg_ecb(1'b0),
`endif
    .cfg_load(cfg_load), .cfg_ready(cfg_ready), .strm(bus.slave),
    .core_data_in(core_data_in), .core_data_en(core_data_en), .core_key_in(core_key_in),
    .core_mode_in(core_mode_in), .core_key_en(core_key_en), .core_data_out(core_data_out),
    .core_busy(core_busy), .core_wr(core_wr), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  // Reference DES on one 64-bit block (bit 1 = MSB numbering, as in the standard tables).
  function automatic des_block_t des_fn(des_block_t key, des_block_t din, logic dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk [16];
    logic [47:0] e;
    logic [63:0] ip, pre, res;
    logic [31:0] l, r, f, p, t;
    logic [5:0]  six;
    int          v;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rr = 0; rr < 16; rr++) begin
      for (int s = 0; s < SH_T[rr]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) sk[rr][47-i] = cd[56-PC2_T[i]];
    end
    for (int i = 0; i < 64; i++) ip[63-i] = din[64-IP_T[i]];
    l = ip[63:32];
    r = ip[31:0];
    for (int rr = 0; rr < 16; rr++) begin
      for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
      e = e ^ sk[dec ? 15 - rr : rr];
      for (int s = 0; s < 8; s++) begin
        six = e[47-6*s -: 6];
        v = SBOX[s*64 + int'({six[5], six[0]})*16 + int'(six[4:1])];
        f[31-4*s -: 4] = v[3:0];
      end
      for (int i = 0; i < 32; i++) p[31-i] = f[32-P_T[i]];
      t = l ^ p;
      l = r;
      r = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
    return res;
  endfunction

  // Behavioural iterative DES core.
  des_block_t ck_key, ck_res;
  logic       ck_mode;
  int         ck_cnt;
  always @(posedge clk) begin
    if (!rst) begin
      core_busy <= 1'b0;
      core_wr   <= 1'b0;
      ck_cnt    <= 0;
    end else if (clk_en) begin
      core_wr <= 1'b0;
      if (core_key_en) begin
        ck_key  <= core_key_in;
        ck_mode <= core_mode_in;
      end
      if (core_data_en) begin
        core_busy <= 1'b1;
        ck_cnt    <= CORE_LAT;
        ck_res    <= des_fn(ck_key, core_data_in, ck_mode);
      end else if (core_busy) begin
        if (ck_cnt == 1) begin
          core_busy     <= 1'b0;
          core_wr       <= 1'b1;
          core_data_out <= ck_res;
        end
        ck_cnt <= ck_cnt - 1;
      end
    end
  end

  // Strobe-shape monitor: data_en must be one qualified cycle wide and never hit a busy core.
  logic den_prev = 1'b0;
  int   den_wide = 0, den_busy = 0;
  always @(posedge clk) begin
    if (!rst) den_prev <= 1'b0;
    else if (clk_en) begin
      if (core_data_en && den_prev) den_wide <= den_wide + 1;
      if (core_data_en && core_busy) den_busy <= den_busy + 1;
      den_prev <= core_data_en;
    end
  end

  int n_checks = 0, n_errors = 0;
  logic en_rand = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {des_block_t data; logic last;} exp_t;
  exp_t       sb[$];
  int         exp_cnt = 0;
  des_block_t m_key, m_iv, m_chain;
  logic       m_dec;

  // CBC software model: returns the expected result and advances the model chain.
  function automatic des_block_t model_blk(des_block_t din, logic last);
    des_block_t o;
    if (m_dec) begin
      o = des_fn(m_key, din, 1'b1) ^ m_chain;
      m_chain = last ? m_iv : din;
    end else begin
      o = des_fn(m_key, din ^ m_chain, 1'b0);
      m_chain = last ? m_iv : o;
    end
    return o;
  endfunction

  task automatic step();
    @(negedge clk);
    clk_en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic do_cfg(input des_block_t key, input des_block_t iv, input logic dec);
    logic fired = 1'b0;
    int   n = 0;
    cfg_key = key; cfg_iv = iv; cfg_decrypt = dec; cfg_load = 1'b1;
    while (!fired && n < 200) begin
      #1 fired = cfg_ready && clk_en;
      step();
      n++;
    end
    cfg_load = 1'b0;
    chk("cfg_handshake", 64'(fired), 64'd1);
    m_key = key; m_iv = iv; m_chain = iv; m_dec = dec;
  endtask

  task automatic send(input des_block_t d, input logic last, input des_block_t exp, input logic push);
    logic fired = 1'b0;
    int   n = 0;
    bus.in_data = d; bus.in_last = last; bus.in_valid = 1'b1;
    while (!fired && n < 500) begin
      #1 fired = bus.in_ready && clk_en;
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    chk("in_handshake", 64'(fired), 64'd1);
    if (fired && push) sb.push_back('{exp, last});
  endtask

  task automatic recv();
    logic got = 1'b0;
    int   n = 0;
    exp_t e;
    bus.out_ready = 1'b1;
    while (!got && n < 1000) begin
      #1;
      if (bus.out_valid && clk_en) begin
        got = 1'b1;
        if (sb.size() == 0) chk("sb_empty", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          exp_cnt++;
          chk("out_data", bus.out_data, e.data);
          chk("out_last", 64'(bus.out_last), 64'(e.last));
          chk("blk_cnt", 64'(blk_cnt), 64'(exp_cnt % 4));
        end
      end
      step();
      n++;
    end
    bus.out_ready = 1'b0;
    if (!got) chk("recv_timeout", 64'd0, 64'd1);
  endtask

  task automatic xfer(input des_block_t d, input logic last);
    des_block_t e;
    e = model_blk(d, last);
    send(d, last, e, 1'b1);
    recv();
  endtask

  task automatic chk_reset(input string tag);
    #1;
    chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_out_flags"}, {62'd0, bus.out_valid, bus.out_last}, 64'd0);
    chk({tag, "_out_data"}, bus.out_data, 64'd0);
    chk({tag, "_pulses"}, {62'd0, core_data_en, core_key_en}, 64'd0);
    chk({tag, "_blk_cnt"}, 64'(blk_cnt), 64'd0);
  endtask

  task automatic stray_valid();
    int rdy = 0;
    bus.in_data = 64'hDEAD_BEEF_0000_0001; bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 if (bus.in_ready) rdy++;
      step();
    end
    bus.in_valid = 1'b0;
    chk("no_cfg_in_ready", 64'(rdy), 64'd0);
  endtask

  localparam des_block_t KEY0 = 64'h1334_5779_9BBC_DFF1;
  localparam des_block_t IV1  = 64'h1122_3344_5566_7788;

  des_block_t pt [3];
  des_block_t ct [3];

  initial begin
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    pt[0] = 64'h0001_0203_0405_0607;
    pt[1] = 64'hA5A5_5A5A_F00F_0FF0;
    pt[2] = 64'hFFFF_0000_1234_5678;
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    chk_reset("reset");
    step();
    stray_valid();

    // Known-answer single block, both directions.
    do_cfg(KEY0, 64'd0, 1'b0);
    void'(model_blk(64'h0123_4567_89AB_CDEF, 1'b1));
    send(64'h0123_4567_89AB_CDEF, 1'b1, 64'h85E8_1354_0F0A_B405, 1'b1);
    recv();
    do_cfg(KEY0, 64'd0, 1'b1);
    void'(model_blk(64'h85E8_1354_0F0A_B405, 1'b1));
    send(64'h85E8_1354_0F0A_B405, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1);
    recv();

    // Three-block CBC message, sent twice to show the chain rewinds to the IV.
    do_cfg(KEY0, IV1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ct[i] = model_blk(pt[i], i == 2);
      send(pt[i], i == 2, ct[i], 1'b1);
      recv();
    end
    for (int i = 0; i < 3; i++) begin
      void'(model_blk(pt[i], i == 2));
      send(pt[i], i == 2, ct[i], 1'b1);
      recv();
    end
    do_cfg(KEY0, IV1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      void'(model_blk(ct[i], i == 2));
      send(ct[i], i == 2, pt[i], 1'b1);
      recv();
    end

    // Backpressure with a toggling clock enable.
    begin
      des_block_t snap;
      int n = 0, chg = 0, rdy = 0, den = 0;
      logic seen = 1'b0;
      en_rand = 1'b1;
      do_cfg(KEY0, IV1, 1'b0);
      send(pt[1], 1'b0, model_blk(pt[1], 1'b0), 1'b1);
      while (!seen && n < 500) begin
        #1 seen = bus.out_valid;
        if (!seen) step();
        n++;
      end
      chk("bp_out_valid", 64'(seen), 64'd1);
      snap = bus.out_data;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (bus.out_data !== snap || !bus.out_valid) chg++;
        if (bus.in_ready) rdy++;
        if (core_data_en) den++;
        step();
      end
      chk("bp_stable", 64'(chg), 64'd0);
      chk("bp_in_ready", 64'(rdy), 64'd0);
      chk("bp_no_data_en", 64'(den), 64'd0);
      recv();
      en_rand = 1'b0;
      step();
    end

    // Reset while the core is busy; the aborted block is never expected.
    begin
      int n = 0;
      logic busy = 1'b0;
      send(pt[2], 1'b1, 64'd0, 1'b0);
      while (!busy && n < 50) begin
        #1 busy = core_busy;
        if (!busy) step();
        n++;
      end
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      chk_reset("mid_reset");
      exp_cnt = 0;
      step();
      stray_valid();
    end

    // Configure with a competing cfg_load during KEY, then five blocks through the 2-bit counter.
    do_cfg(KEY0, IV1, 1'b0);
    cfg_key = 64'hFFFF_FFFF_FFFF_FFFF; cfg_iv = 64'd0; cfg_load = 1'b1;
    #1 chk("key_cfg_ready", 64'(cfg_ready), 64'd0);
    step();
    cfg_load = 1'b0;
    for (int i = 0; i < 5; i++) xfer(pt[i % 3] ^ 64'(i), i == 4);
    #1 chk("blk_cnt_wrap", 64'(blk_cnt), 64'd1);

    chk("data_en_width", 64'(den_wide), 64'd0);
    chk("data_en_busy", 64'(den_busy), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/des_cbc_ctrl.md
Name: des_cbc_ctrl

Overview:
- Upstream controller for the iterative single-block DES core.
- Takes a 64-bit block stream over valid/ready and programs key, mode and IV into the core.
- Applies CBC chaining around the core, returns results over valid/ready, and tracks message boundaries with a last flag.
- Sits between the host/bus interface and the DES core; a top level instantiates both and wires them port to port.

Parameters:
CNT_W, 16, width of the processed-block statistics counter (wraps)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
clk_en  in  1  global clock enable; all state advances only when high
cfg_key  in  64  DES key incl. parity bits
cfg_iv  in  64  CBC initial vector
cfg_decrypt  in  1  1=decrypt, 0=encrypt
cfg_load  in  1  pulse: latch cfg_* and program core
cfg_ready  out  1  high when cfg_load is accepted
in_data  in  64  plaintext/ciphertext block
in_valid  in  1  input block valid
in_last  in  1  block is last of message
in_ready  out  1  block accepted when in_valid&in_ready&clk_en
out_data  out  64  result block
out_valid  out  1  result valid
out_last  out  1  result is last of message
out_ready  in  1  downstream accepts
core_data_in  out  64  to core data_in
core_data_en  out  1  to core data_en, one-cycle pulse
core_key_in  out  64  to core key_in
core_mode_in  out  1  to core mode_in (1=decrypt)
core_key_en  out  1  to core key_en, one-cycle pulse
core_data_out  in  64  from core data_out
core_busy  in  1  from core des_busy
core_wr  in  1  from core des_wr
blk_cnt  out  CNT_W  blocks completed since reset

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE; cfg_ready=1, in_ready=0, out_valid=0, out_last=0, out_data=0, core_data_en=0, core_key_en=0, blk_cnt=0, key_loaded=0. Reset mid-operation aborts silently; the core must be reprogrammed.
- States: IDLE, KEY, READY, BUSY, OUT.
- IDLE: cfg_ready=1, in_ready=0. cfg_load -> latch key/iv/decrypt; chain<=cfg_iv; core_key_en pulse next cycle; go to KEY.
- KEY: 2-bit counter waits 2 clk_en cycles (core programming latency), then key_loaded=1 and go to READY. cfg_load is ignored in KEY.
- READY: in_ready=1, cfg_ready=1.
  - cfg_load in READY re-enters KEY, as from IDLE.
  - If cfg_load and in_valid occur together, cfg_load wins and in_ready is deasserted that cycle.
- Input handshake in READY, encrypt: core_data_in <= in_data ^ chain.
- Input handshake in READY, decrypt: core_data_in <= in_data and pend <= in_data.
- Input handshake in READY, both directions: last_r <= in_last; core_data_en pulses for 1 cycle; go to BUSY.
- BUSY: in_ready=0. Waits for core_wr. core_data_en is never asserted while core_busy=1.
- On core_wr, encrypt: out_data <= core_data_out; chain <= core_data_out.
- On core_wr, decrypt: out_data <= core_data_out ^ chain; chain <= pend.
- On core_wr, both directions: out_valid<=1, out_last<=last_r, blk_cnt++ (wraps at 2^CNT_W), go to OUT.
- If last_r=1, chain <= iv_reg instead, so the next message restarts from the IV.
- OUT: holds out_* stable until out_ready&clk_en, then out_valid<=0 and go to READY.
- Latency: input accept to out_valid is core latency + 2 cycles.
- Throughput: one block per core round-trip; no overlap.
- clk_en low freezes every register, including the KEY counter; pulses stay one clk_en-qualified cycle wide.
- core_mode_in is held at the latched decrypt value.
- core_key_in is held at the latched key.
- A core_wr outside BUSY is ignored. Verification asserts it never occurs.

Optional Feature:
- Macro DES_CBC_ECB_EN.
- Defined: adds input port cfg_ecb (1 bit), latched on cfg_load. When latched 1, the chain XOR is bypassed in both directions (ECB) and chain is not updated.
- Undefined: port is absent; always CBC.

Decomposition:
- Package des_pkg holds:
  - typedef des_block_t (logic [63:0])
  - ctrl state enum
  - localparam KEY_WAIT_CYCLES = 2
- No sub-module needed.
- The chaining XOR/select is a single function in des_pkg so a future CTR/OFB controller can share it.

Test Plan:
- Single block:
  - Stimulus: key 133457799BBCDFF1, iv 0, encrypt, in 0123456789ABCDEF, last=1.
  - Response: out_data 85E813540F0AB405, out_last=1, blk_cnt=1.
- Decrypt:
  - Stimulus: same key, iv 0, in 85E813540F0AB405.
  - Response: out 0123456789ABCDEF.
- Three-block CBC message:
  - Stimulus: iv 1122334455667788, encrypt; then decrypt the result with the same key/iv.
  - Response: ciphertext matches the software model; the decrypt round-trip returns the original blocks; chain resets to iv after the last block.
- Backpressure and clk_en:
  - Stimulus: hold out_ready=0 for 20 cycles; toggle clk_en 50%.
  - Response: out_data stable, in_ready=0 throughout, no core_data_en pulse, result unchanged.
- Mid-operation reset and stray config:
  - Stimulus: rst=0 during BUSY; then in_valid without cfg_load; then cfg_load during KEY.
  - Response: after the reset, outputs are at their reset values. With in_valid and no cfg_load, in_ready stays 0. cfg_load during KEY is ignored.
- blk_cnt wrap:
  - Stimulus: CNT_W=2; 5 blocks.
  - Response: blk_cnt reads 1; each core_data_en pulse is exactly 1 cycle wide.
